// File: rtl/pong_pkg.sv
// Shared definitions for the Ping-Pong game blocks: FSM state encodings,
// player identifiers and default match-rule parameters.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam int unsigned WIN_SCORE_DEF  = 11;
    localparam int unsigned WIN_MARGIN_DEF = 2;

endpackage

// File: rtl/score_keeper_win_detect.sv
// win_detect: combinational match-rule evaluator.
// Ports:
//   score_p1_i, score_p2_i : current scores (8-bit unsigned)
//   p1_win_o, p2_win_o     : player has reached WIN_SCORE with a lead >= WIN_MARGIN
//   deuce_o                : both players are at WIN_SCORE-1 or above
module win_detect
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE  = WIN_SCORE_DEF,
    parameter int unsigned WIN_MARGIN = WIN_MARGIN_DEF
) (
    input  logic [7:0] score_p1_i,
    input  logic [7:0] score_p2_i,
    output logic       p1_win_o,
    output logic       p2_win_o,
    output logic       deuce_o
);

    logic [9:0] s1;
    logic [9:0] s2;
    logic [9:0] win_score;
    logic [9:0] win_margin;

    assign s1         = {2'b00, score_p1_i};
    assign s2         = {2'b00, score_p2_i};
    assign win_score  = 10'(WIN_SCORE);
    assign win_margin = 10'(WIN_MARGIN);

    // Lead test written as an addition so a trailing player never wraps
    // around into a huge unsigned difference.
    assign p1_win_o = (s1 >= win_score) && (s1 >= s2 + win_margin);
    assign p2_win_o = (s2 >= win_score) && (s2 >= s1 + win_margin);
    assign deuce_o  = (s1 + 10'd1 >= win_score) && (s2 + 10'd1 >= win_score);

endmodule

// File: rtl/score_keeper.sv
// score_keeper: match-score controller for the Ping-Pong game.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   new_game              : pulse, clears the match and starts play
//   point_p1, point_p2    : point pulses from ball/paddle logic
//   inc_a / inc_b         : operand to / result from the external incrementer
//   score_p1, score_p2    : player scores
//   ready                 : a point pulse will be accepted this cycle
//   serve                 : current server (0 = P1, 1 = P2)
//   game_over, winner     : match decided / winning player
//   collision             : both point pulses arrived together (P1 kept)
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE  = WIN_SCORE_DEF,
    parameter int unsigned WIN_MARGIN = WIN_MARGIN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic [7:0] inc_b,
    output logic [7:0] inc_a,
    output logic [7:0] score_p1,
    output logic [7:0] score_p2,
    output logic       ready,
    output logic       serve,
    output logic       game_over,
    output logic       winner,
    output logic       collision
);

    state_e     state_q,     state_d;
    logic       sel_q,       sel_d;
    logic [7:0] score_p1_q,  score_p1_d;
    logic [7:0] score_p2_q,  score_p2_d;
    logic [8:0] total_q,     total_d;
    logic       serve_q,     serve_d;
    logic       over_q,      over_d;
    logic       winner_q,    winner_d;
    logic       collision_q, collision_d;

    logic p1_win;
    logic p2_win;
    logic deuce;

    win_detect #(
        .WIN_SCORE  (WIN_SCORE),
        .WIN_MARGIN (WIN_MARGIN)
    ) u_win_detect (
        .score_p1_i (score_p1_q),
        .score_p2_i (score_p2_q),
        .p1_win_o   (p1_win),
        .p2_win_o   (p2_win),
        .deuce_o    (deuce)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= P1;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            total_q     <= '0;
            serve_q     <= 1'b0;
            over_q      <= 1'b0;
            winner_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            total_q     <= total_d;
            serve_q     <= serve_d;
            over_q      <= over_d;
            winner_q    <= winner_d;
            collision_q <= collision_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        total_d     = total_q;
        serve_d     = serve_q;
        over_d      = over_q;
        winner_d    = winner_q;
        collision_d = 1'b0;

        if (new_game) begin
            state_d    = ST_PLAY;
            sel_d      = P1;
            score_p1_d = '0;
            score_p2_d = '0;
            total_d    = '0;
            serve_d    = 1'b0;
            over_d     = 1'b0;
            winner_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_PLAY: begin
                    if (point_p1) begin
                        sel_d       = P1;
                        collision_d = point_p2;
                        state_d     = ST_UPDATE;
                    end else if (point_p2) begin
                        sel_d   = P2;
                        state_d = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    // A score already at 255 holds; the incrementer's wrap is never stored.
                    if (sel_q == P1) begin
                        score_p1_d = (score_p1_q == 8'hFF) ? 8'hFF : inc_b;
                    end else begin
                        score_p2_d = (score_p2_q == 8'hFF) ? 8'hFF : inc_b;
                    end
                    total_d = (total_q == 9'h1FF) ? total_q : total_q + 9'd1;
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (p1_win) begin
                        over_d   = 1'b1;
                        winner_d = P1;
                        state_d  = ST_OVER;
                    end else if (p2_win) begin
                        over_d   = 1'b1;
                        winner_d = P2;
                        state_d  = ST_OVER;
                    end else begin
                        // total_q already includes the point just scored.
                        if (deuce || !total_q[0]) begin
                            serve_d = ~serve_q;
                        end
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign inc_a     = (sel_q == P1) ? score_p1_q : score_p2_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign ready     = (state_q == ST_PLAY);
    assign serve     = serve_q;
    assign game_over = over_q;
    assign winner    = winner_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, new_game, point_p1, point_p2;

    logic [7:0] a_inc_a, a_inc_b, a_s1, a_s2;
    logic       a_ready, a_serve, a_go, a_win, a_col;
    logic [7:0] b_inc_a, b_inc_b, b_s1, b_s2;
    logic       b_ready, b_serve, b_go, b_win, b_col;

    // External incrementers: plain 8-bit wrap, so saturation must come from the DUT.
    assign a_inc_b = a_inc_a + 8'd1;
    assign b_inc_b = b_inc_a + 8'd1;

    score_keeper #(.WIN_SCORE(11), .WIN_MARGIN(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .point_p1(point_p1), .point_p2(point_p2), .inc_b(a_inc_b),
        .inc_a(a_inc_a), .score_p1(a_s1), .score_p2(a_s2), .ready(a_ready),
        .serve(a_serve), .game_over(a_go), .winner(a_win), .collision(a_col)
    );

    score_keeper #(.WIN_SCORE(255), .WIN_MARGIN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .point_p1(point_p1), .point_p2(point_p2), .inc_b(b_inc_b),
        .inc_a(b_inc_a), .score_p1(b_s1), .score_p2(b_s2), .ready(b_ready),
        .serve(b_serve), .game_over(b_go), .winner(b_win), .collision(b_col)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model of the match rules for dut_a (WIN_SCORE 11, margin 2).
    int m_s1, m_s2, m_tot, m_serve, m_over, m_win;

    function automatic void model_new();
        m_s1 = 0; m_s2 = 0; m_tot = 0; m_serve = 0; m_over = 0; m_win = 0;
    endfunction

    function automatic void model_point(input int who);
        if (m_over != 0) return;
        if (who == 0) m_s1 = (m_s1 < 255) ? m_s1 + 1 : 255;
        else          m_s2 = (m_s2 < 255) ? m_s2 + 1 : 255;
        m_tot = (m_tot < 511) ? m_tot + 1 : 511;
        if (m_s1 >= 11 && m_s1 - m_s2 >= 2) begin
            m_over = 1; m_win = 0;
        end else if (m_s2 >= 11 && m_s2 - m_s1 >= 2) begin
            m_over = 1; m_win = 1;
        end else if ((m_s1 >= 10 && m_s2 >= 10) || (m_tot % 2 == 0)) begin
            m_serve = 1 - m_serve;
        end
    endfunction

    function automatic logic [18:0] model_vec();
        return {8'(m_s1), 8'(m_s2), m_serve[0], m_over[0], m_win[0]};
    endfunction

    task automatic do_new_game();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
        model_new();
    endtask

    // Pulse at edge N; optional stray pulses land in the UPDATE and CHECK
    // cycles. Returns just after edge N+2.
    task automatic send_point(input logic p1, input logic p2, input logic stray);
        @(negedge clk); point_p1 = p1;    point_p2 = p2;
        @(negedge clk); point_p1 = stray; point_p2 = stray;
        @(negedge clk); point_p1 = 1'b0;  point_p2 = stray;
        @(negedge clk); point_p1 = 1'b0;  point_p2 = 1'b0;
    endtask

    task automatic test_reset();
        logic [44:0] got;
        got = {a_s1, a_s2, a_inc_a, a_ready, a_serve, a_go, a_win, a_col,
               b_s1, b_s2, b_ready, b_go};
        chk_cnt++;
        if (got !== '0) $display("FAIL reset_values got=%h exp=0", got);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (a_ready !== 1'b0) $display("FAIL idle_not_ready got=%b exp=0", a_ready);
        else pass_cnt++;
        do_new_game();
        chk_cnt++;
        if ({a_ready, a_s1, a_s2, a_go} !== {1'b1, 17'd0})
            $display("FAIL new_game_ready got=%b/%0d/%0d/%b exp=1/0/0/0", a_ready, a_s1, a_s2, a_go);
        else pass_cnt++;
    endtask

    task automatic test_straight_win();
        do_new_game();
        for (int i = 0; i < 11; i++) begin
            send_point(1'b1, 1'b0, 1'b0);
            model_point(0);
            chk_cnt++;
            if ({a_s1, a_s2, a_serve, a_go, a_win} !== model_vec())
                $display("FAIL straight_pt%0d got=%h exp=%h", i, {a_s1, a_s2, a_serve, a_go, a_win}, model_vec());
            else pass_cnt++;
        end
        chk_cnt++;
        if ({a_s1, a_s2, a_go, a_win, a_ready} !== {8'd11, 8'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL straight_final got=%0d-%0d go=%b w=%b rdy=%b exp=11-0 go=1 w=0 rdy=0",
                     a_s1, a_s2, a_go, a_win, a_ready);
        else pass_cnt++;
        // OVER is frozen: further points are ignored.
        send_point(1'b0, 1'b1, 1'b0);
        chk_cnt++;
        if ({a_s1, a_s2, a_go} !== {8'd11, 8'd0, 1'b1})
            $display("FAIL over_frozen got=%0d-%0d go=%b exp=11-0 go=1", a_s1, a_s2, a_go);
        else pass_cnt++;
    endtask

    task automatic test_deuce();
        logic prev;
        int seq [4] = '{1, 0, 1, 1};
        do_new_game();
        for (int i = 0; i < 20; i++) begin
            send_point(i % 2 == 0, i % 2 == 1, 1'b0);
            model_point(i % 2);
        end
        chk_cnt++;
        if ({a_s1, a_s2, a_go} !== {8'd10, 8'd10, 1'b0})
            $display("FAIL deuce_10_10 got=%0d-%0d go=%b exp=10-10 go=0", a_s1, a_s2, a_go);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            prev = a_serve;
            send_point(seq[i] == 0, seq[i] == 1, 1'b0);
            model_point(seq[i]);
            chk_cnt++;
            if ({a_s1, a_s2, a_serve, a_go, a_win} !== model_vec())
                $display("FAIL deuce_pt%0d got=%h exp=%h", i, {a_s1, a_s2, a_serve, a_go, a_win}, model_vec());
            else pass_cnt++;
            if (i < 3) begin
                chk_cnt++;
                if (a_serve !== ~prev) $display("FAIL deuce_serve_toggle%0d got=%b exp=%b", i, a_serve, ~prev);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if ({a_s1, a_s2, a_go, a_win} !== {8'd11, 8'd13, 1'b1, 1'b1})
            $display("FAIL deuce_final got=%0d-%0d go=%b w=%b exp=11-13 go=1 w=1", a_s1, a_s2, a_go, a_win);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        do_new_game();
        for (int i = 0; i < 7; i++) begin
            send_point(i < 3, i >= 3, 1'b0);
            model_point(i < 3 ? 0 : 1);
        end
        @(negedge clk); point_p1 = 1'b1; point_p2 = 1'b1;
        @(negedge clk); point_p1 = 1'b0; point_p2 = 1'b0;
        chk_cnt++;
        if (a_col !== 1'b1) $display("FAIL collision_high got=%b exp=1", a_col);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (a_col !== 1'b0) $display("FAIL collision_one_cycle got=%b exp=0", a_col);
        else pass_cnt++;
        @(negedge clk);
        model_point(0);
        chk_cnt++;
        if ({a_s1, a_s2, a_serve, a_go, a_win} !== model_vec())
            $display("FAIL collision_score got=%h exp=%h", {a_s1, a_s2, a_serve, a_go, a_win}, model_vec());
        else pass_cnt++;
        chk_cnt++;
        if ({a_s1, a_s2} !== {8'd4, 8'd4})
            $display("FAIL collision_4_4 got=%0d-%0d exp=4-4", a_s1, a_s2);
        else pass_cnt++;
    endtask

    task automatic test_drop_busy();
        do_new_game();
        @(negedge clk); point_p1 = 1'b1;
        @(negedge clk); point_p1 = 1'b1;
        chk_cnt++;
        if (a_ready !== 1'b0) $display("FAIL busy_ready got=%b exp=0", a_ready);
        else pass_cnt++;
        @(negedge clk); point_p1 = 1'b0;
        @(negedge clk);
        model_point(0);
        chk_cnt++;
        if ({a_s1, a_s2, a_ready} !== {8'd1, 8'd0, 1'b1})
            $display("FAIL busy_drop got=%0d-%0d rdy=%b exp=1-0 rdy=1", a_s1, a_s2, a_ready);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int r;
        logic p1, p2, stray;
        do_new_game();
        for (int i = 0; i < 120; i++) begin
            r     = $urandom_range(0, 9);
            p1    = (r <= 4) || (r == 9);
            p2    = (r >= 5);
            stray = 1'($urandom_range(0, 1));
            send_point(p1, p2, stray);
            model_point(p1 ? 0 : 1);
            chk_cnt++;
            if ({a_s1, a_s2, a_serve, a_go, a_win} !== model_vec())
                $display("FAIL random_pt%0d got=%h exp=%h", i, {a_s1, a_s2, a_serve, a_go, a_win}, model_vec());
            else pass_cnt++;
            if (m_over != 0 && $urandom_range(0, 1) == 1) do_new_game();
        end
    endtask

    task automatic test_saturate();
        do_new_game();
        for (int i = 0; i < 508; i++) send_point(i % 2 == 0, i % 2 == 1, 1'b0);
        chk_cnt++;
        if ({b_s1, b_s2, b_go} !== {8'd254, 8'd254, 1'b0})
            $display("FAIL sat_254 got=%0d-%0d go=%b exp=254-254 go=0", b_s1, b_s2, b_go);
        else pass_cnt++;
        send_point(1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if ({b_s1, b_s2, b_go} !== {8'd255, 8'd254, 1'b0})
            $display("FAIL sat_255 got=%0d-%0d go=%b exp=255-254 go=0", b_s1, b_s2, b_go);
        else pass_cnt++;
        send_point(1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if ({b_s1, b_s2, b_go, b_ready} !== {8'd255, 8'd254, 1'b0, 1'b1})
            $display("FAIL sat_hold got=%0d-%0d go=%b rdy=%b exp=255-254 go=0 rdy=1", b_s1, b_s2, b_go, b_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_update();
        do_new_game();
        send_point(1'b1, 1'b0, 1'b0);
        send_point(1'b1, 1'b0, 1'b0);
        @(negedge clk); point_p1 = 1'b1;
        @(negedge clk); point_p1 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({a_s1, a_s2, a_inc_a, a_ready, a_serve, a_go, a_win, a_col} !== '0)
            $display("FAIL midreset_values got=%0d-%0d inc=%0d rdy=%b sv=%b go=%b exp=all 0",
                     a_s1, a_s2, a_inc_a, a_ready, a_serve, a_go);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({a_s1, a_ready} !== {8'd0, 1'b0})
            $display("FAIL midreset_idle got=%0d rdy=%b exp=0 rdy=0", a_s1, a_ready);
        else pass_cnt++;
        do_new_game();
        send_point(1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if ({a_s1, a_s2, a_go} !== {8'd1, 8'd0, 1'b0})
            $display("FAIL midreset_restart got=%0d-%0d go=%b exp=1-0 go=0", a_s1, a_s2, a_go);
        else pass_cnt++;
    endtask

    initial begin
        rst_n    = 1'b0;
        new_game = 1'b0;
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        model_new();
        #22;
        test_reset();
        test_straight_win();
        test_deuce();
        test_collision();
        test_drop_busy();
        test_random();
        test_saturate();
        test_reset_mid_update();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
